// File: rtl/inst_bus_responder.sv
// inst_bus_responder: instruction-fetch bus responder with a preloadable word
// array, configurable fixed latency and several in-order outstanding reads.
//
// Handshake semantics (both channels): a transfer happens at a rising edge
// where valid and ready are both high. The producer keeps the payload stable
// while valid is high and ready is low. i_rdata/i_rerr are forced to zero
// whenever i_rdata_valid is low.
module inst_bus_responder #(
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  MEM_WORDS  = 1024,
    parameter int                  LATENCY    = 2,
    parameter int                  FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_raddr_valid,
    output logic                  i_raddr_ready,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic                  i_rdata_valid,
    input  logic                  i_rdata_ready,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_rerr,
    input  logic                  mem_wr_en,
    input  logic [ADDR_WIDTH-1:0] mem_wr_addr,
    input  logic [DATA_WIDTH-1:0] mem_wr_data
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(LATENCY + 1);

    // First byte address past the end of the array.
    localparam logic [ADDR_WIDTH:0]  ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS) << 2;
    localparam logic [CNT_W-1:0]     DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [AGE_W-1:0]     LAT_C      = AGE_W'(LATENCY);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic                  err_q  [FIFO_DEPTH];
    logic [AGE_W-1:0]      age_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  rd_err;
    logic                  wr_err;
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  push;
    logic                  pop;
    logic                  head_valid;

    // Misaligned or beyond the array: such reads return ERR_DATA, such writes are dropped.
    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] != 2'b00) || ({1'b0, a} >= ADDR_LIMIT);
    endfunction

    assign rd_idx  = i_raddr[2 +: IDX_W];
    assign wr_idx  = mem_wr_addr[2 +: IDX_W];
    assign rd_err  = addr_err(i_raddr);
    assign wr_err  = addr_err(mem_wr_addr);
    // Combinational array read: a same-edge preload write lands via NBA, so the
    // captured word is always the pre-write value.
    assign rd_word = rd_err ? ERR_DATA : mem[rd_idx];

    // No same-cycle pop bypass: a full FIFO refuses addresses even while popping.
    assign i_raddr_ready = rst && (count < DEPTH_C);
    assign head_valid    = rst && (count != '0) && (age_q[rd_ptr] == LAT_C);
    assign i_rdata_valid = head_valid;
    assign i_rdata       = head_valid ? data_q[rd_ptr] : '0;
    assign i_rerr        = head_valid && err_q[rd_ptr];

    assign push = i_raddr_valid && i_raddr_ready;
    assign pop  = head_valid && i_rdata_ready;

    // Preload port: array contents are never reset and writes ignore the fetch channel.
    always_ff @(posedge clk) begin
        if (mem_wr_en && !wr_err) begin
            mem[wr_idx] <= mem_wr_data;
        end
    end

    // FIFO pointers and occupancy count; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO entries: capture on push with age 0, otherwise age saturates at LATENCY.
    // Free slots age too; that is harmless because a push always restarts the age.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (!rst) begin
                data_q[i] <= '0;
                err_q[i]  <= 1'b0;
                age_q[i]  <= '0;
            end else if (push && (wr_ptr == PTR_W'(i))) begin
                data_q[i] <= rd_word;
                err_q[i]  <= rd_err;
                age_q[i]  <= '0;
            end else if (age_q[i] != LAT_C) begin
                age_q[i]  <= age_q[i] + AGE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_bus_responder.sv
// Testbench for inst_bus_responder: directed scenarios plus a randomized phase,
// all checked cycle by cycle against a transaction-level reference model.
module tb_inst_bus_responder;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int MW    = 1024;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam logic [DW-1:0] ERRW = 32'hDEADBEEF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst           = 1'b0;
    logic          i_raddr_valid = 1'b0;
    logic          i_raddr_ready;
    logic [AW-1:0] i_raddr       = '0;
    logic          i_rdata_valid;
    logic          i_rdata_ready = 1'b0;
    logic [DW-1:0] i_rdata;
    logic          i_rerr;
    logic          mem_wr_en     = 1'b0;
    logic [AW-1:0] mem_wr_addr   = '0;
    logic [DW-1:0] mem_wr_data   = '0;

    inst_bus_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW),
        .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .ERR_DATA(ERRW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_raddr_valid(i_raddr_valid),
        .i_raddr_ready(i_raddr_ready),
        .i_raddr      (i_raddr),
        .i_rdata_valid(i_rdata_valid),
        .i_rdata_ready(i_rdata_ready),
        .i_rdata      (i_rdata),
        .i_rerr       (i_rerr),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Memory as a plain array, requests as a queue of {err,data} with the
    // edge number at which they were accepted.
    logic [DW-1:0] mem_m [MW];
    logic [DW:0]   exp_q [$];
    int            exp_t [$];
    int            cyc = 0;

    function automatic logic ref_err(input logic [AW-1:0] a);
        return (a % 4 != 0) || (a >= 4 * MW);
    endfunction

    function automatic logic exp_valid();
        return rst && (exp_q.size() > 0) && (cyc - exp_t[0] >= LAT);
    endfunction

    function automatic logic exp_ready();
        return rst && (exp_q.size() < DEPTH);
    endfunction

    always @(posedge clk) begin : model_b
        logic        v;
        logic        r;
        logic [DW:0] word;
        v = exp_valid();
        r = exp_ready();
        cyc++;
        if (!rst) begin
            exp_q.delete();
            exp_t.delete();
        end else begin
            if (v && i_rdata_ready) begin
                void'(exp_q.pop_front());
                void'(exp_t.pop_front());
            end
            if (i_raddr_valid && r) begin
                if (ref_err(i_raddr)) word = {1'b1, ERRW};
                else                  word = {1'b0, mem_m[i_raddr / 4]};
                exp_q.push_back(word);
                exp_t.push_back(cyc);
            end
        end
        if (mem_wr_en && !ref_err(mem_wr_addr)) mem_m[mem_wr_addr / 4] = mem_wr_data;
    end

    // ---------------- monitor / scoreboard ----------------
    logic [DW:0] got_q [$];
    int          got_t [$];
    int          n_acc      = 0;
    int          ready_drop = 0;
    logic        stream_on  = 1'b0;

    always begin
        @(negedge clk);
        #1;
        check("ready", i_raddr_ready, exp_ready());
        check("valid", i_rdata_valid, exp_valid());
        if (exp_valid() && i_rdata_valid) begin
            check("rdata", i_rdata, exp_q[0][DW-1:0]);
            check("rerr", i_rerr, exp_q[0][DW]);
        end
        if (i_rdata_valid && i_rdata_ready) begin
            got_q.push_back({i_rerr, i_rdata});
            got_t.push_back(cyc);
        end
        if (i_raddr_valid && i_raddr_ready) n_acc++;
        if (stream_on && i_raddr_valid && !i_raddr_ready) ready_drop++;
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic av, input logic [AW-1:0] a, input logic rr,
                         input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        @(negedge clk);
        i_raddr_valid = av;
        i_raddr       = a;
        i_rdata_ready = rr;
        mem_wr_en     = we;
        mem_wr_addr   = wa;
        mem_wr_data   = wd;
    endtask

    task automatic idle(input logic rr);
        drive(1'b0, '0, rr, 1'b0, '0, '0);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive(1'b0, '0, 1'b1, 1'b1, a, d);
    endtask

    task automatic fetch(input logic [AW-1:0] a);
        drive(1'b1, a, 1'b1, 1'b0, '0, '0);
    endtask

    // Single fetch on an idle responder: valid must rise exactly LAT edges after accept.
    task automatic single_fetch_timed(input logic [AW-1:0] a, input logic [DW-1:0] w, input string tag);
        fetch(a);
        for (int k = 0; k < LAT; k++) begin
            idle(1'b1);
            #2;
            check({tag, "_early"}, i_rdata_valid, 1'b0);
        end
        idle(1'b1);
        #2;
        check({tag, "_valid"}, i_rdata_valid, 1'b1);
        check({tag, "_data"}, i_rdata, w);
        check({tag, "_err"}, i_rerr, 1'b0);
        repeat (2) idle(1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] hd;
        int            r;

        // reset
        repeat (3) @(negedge clk);
        #2;
        check("rst_rdata", i_rdata, '0);
        check("rst_rerr", i_rerr, 1'b0);
        check("rst_rdy", i_raddr_ready, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // preload
        for (int w = 0; w < 64; w++) preload(AW'(w * 4), $urandom());
        preload(32'h0, 32'h00500093);
        preload(32'h4, 32'h00A00113);
        preload(32'hC, 32'h11111111);
        idle(1'b1);

        // preload and single fetch
        single_fetch_timed(32'h0, 32'h00500093, "fetch0");
        single_fetch_timed(32'h4, 32'h00A00113, "fetch4");

        // streaming
        got_q.delete(); got_t.delete();
        ready_drop = 0;
        stream_on  = 1'b1;
        for (int k = 0; k < 16; k++) fetch(AW'(k * 4));
        idle(1'b1);
        stream_on = 1'b0;
        for (int k = 0; k < 20 && got_q.size() < 16; k++) idle(1'b1);
        check("stream_cnt", got_q.size(), 16);
        check("stream_drop", ready_drop, 0);
        if (got_q.size() == 16) begin
            check("stream_rate", got_t[15] - got_t[0], 15);
            for (int k = 0; k < 16; k++) check("stream_word", got_q[k][DW-1:0], mem_m[k]);
        end

        // backpressure and full
        got_q.delete(); got_t.delete();
        n_acc = 0;
        for (int k = 0; k < 6; k++) drive(1'b1, AW'(64 + 4 * k), 1'b0, 1'b0, '0, '0);
        idle(1'b0);
        #2;
        check("bp_acc", n_acc, 4);
        check("bp_ready", i_raddr_ready, 1'b0);
        hd = i_rdata;
        check("bp_head", hd, mem_m[16]);
        repeat (3) idle(1'b0);
        #2;
        check("bp_hold", i_rdata, hd);
        idle(1'b1);
        #2;
        check("bp_nobypass", i_raddr_ready, 1'b0);
        idle(1'b1);
        #2;
        check("bp_reready", i_raddr_ready, 1'b1);
        for (int k = 0; k < 10 && got_q.size() < 4; k++) idle(1'b1);
        check("bp_cnt", got_q.size(), 4);
        if (got_q.size() == 4)
            for (int k = 0; k < 4; k++) check("bp_word", got_q[k][DW-1:0], mem_m[16 + k]);

        // error accesses
        got_q.delete(); got_t.delete();
        fetch(32'h2);
        fetch(32'h1000);
        fetch(32'h0);
        for (int k = 0; k < 10 && got_q.size() < 3; k++) idle(1'b1);
        check("err_cnt", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("err_mis_data", got_q[0][DW-1:0], ERRW);
            check("err_mis_flag", got_q[0][DW], 1'b1);
            check("err_oor_data", got_q[1][DW-1:0], ERRW);
            check("err_oor_flag", got_q[1][DW], 1'b1);
            check("err_ok_data", got_q[2][DW-1:0], 32'h00500093);
            check("err_ok_flag", got_q[2][DW], 1'b0);
        end

        // write/fetch collision
        got_q.delete(); got_t.delete();
        drive(1'b1, 32'hC, 1'b1, 1'b1, 32'hC, 32'h22222222);
        repeat (4) idle(1'b1);
        fetch(32'hC);
        for (int k = 0; k < 10 && got_q.size() < 2; k++) idle(1'b1);
        check("coll_cnt", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("coll_old", got_q[0][DW-1:0], 32'h11111111);
            check("coll_new", got_q[1][DW-1:0], 32'h22222222);
        end

        // reset mid-operation
        got_q.delete(); got_t.delete();
        drive(1'b1, 32'h0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 32'h4, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 32'h8, 1'b0, 1'b0, '0, '0);
        repeat (2) idle(1'b0);
        idle(1'b0);
        rst = 1'b0;
        #2;
        check("mid_rst_ready", i_raddr_ready, 1'b0);
        check("mid_rst_valid", i_rdata_valid, 1'b0);
        idle(1'b1);
        rst = 1'b1;
        repeat (6) idle(1'b1);
        check("mid_rst_flush", got_q.size(), 0);
        single_fetch_timed(32'h0, 32'h00500093, "post_rst");

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            logic [AW-1:0] a;
            r = $urandom_range(0, 9);
            if (r == 0)      a = AW'($urandom_range(0, 255));
            else if (r == 1) a = AW'(4 * MW + 4 * $urandom_range(0, 63));
            else             a = AW'(4 * $urandom_range(0, 63));
            drive($urandom_range(0, 1) == 1, a, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0, AW'(4 * $urandom_range(0, 63)), $urandom());
            rst = ($urandom_range(0, 99) != 0);
        end
        rst = 1'b1;
        repeat (12) idle(1'b1);
        check("final_idle", i_rdata_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
